vga_fb_fetch_ctrl: RTL and testbench
====================================

Name: vga_fb_fetch_ctrl

Overview:
Framebuffer fetch scheduler for the VGA controller. Once per frame it walks the framebuffer region (FBSTART/FBSIZE) as a sequence of single-outstanding AXI4 INCR read bursts sized by CTRL.BRULEN. It throttles issue on pixel-FIFO free space and pushes returned beats into that FIFO. It sits between the APB register file / timing generator and the AXI4 master port.

Parameters:
ADDR_WIDTH, 32, AXI address and FBSTART width
DATA_WIDTH, 32, AXI read data width; fixed 4 bytes per beat
LVL_WIDTH, 10, width of the FIFO free-space count

Ports:
clk_i  in  1  single clock for all logic
rst_i  in  1  synchronous reset, active-high
en_i  in  1  CTRL.EN
frame_start_i  in  1  one-cycle pulse at frame start (vsync leading edge)
fbstart_i  in  ADDR_WIDTH  framebuffer base byte address; bits[1:0] ignored
fbsize_i  in  32  framebuffer size in bytes; bits[1:0] ignored
brulen_i  in  8  max beats per burst minus 1
fifo_free_i  in  LVL_WIDTH  free entries in the pixel FIFO
arvalid_o  out  1  AR valid
arready_i  in  1  AR ready
araddr_o  out  ADDR_WIDTH  burst start address
arlen_o  out  8  beats minus 1
rvalid_i  in  1  R valid
rready_o  out  1  R ready
rdata_i  in  DATA_WIDTH  R data
rresp_i  in  2  R response
rlast_i  in  1  R last
push_o  out  1  FIFO write strobe
push_data_o  out  DATA_WIDTH  FIFO write data
busy_o  out  1  frame fetch in progress
frame_done_o  out  1  one-cycle pulse when a frame fetch completes
err_o  out  1  sticky error
late_o  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset: state IDLE. All outputs 0. Address, remaining-word and beat counters 0.
- States: IDLE, WAIT_SPACE, ADDR, DATA, DONE.
- IDLE: on frame_start_i && en_i, latch cur_addr={fbstart_i[AW-1:2],2'b00}, rem_words=fbsize_i>>2, blen=brulen_i+1, and clear err_o.
  - rem_words==0: go to DONE.
  - Otherwise: go to WAIT_SPACE.
- burst_words = min(blen, rem_words, (4096 - cur_addr[11:0])>>2). A burst never crosses a 4 KB boundary.
- WAIT_SPACE: go to ADDR when fifo_free_i >= burst_words; burst_words is captured at that transition.
- ADDR: arvalid_o=1, araddr_o=cur_addr, arlen_o=burst_words-1. These stay stable until arready_i; never deassert without a handshake. On handshake go to DATA, beat_cnt=0.
- DATA: rready_o=1.
  - Each rvalid_i&&rready_o beat: push_o=1 and push_data_o=rdata_i in the same cycle (combinational, zero latency). beat_cnt increments.
  - rresp_i!=0 on any beat sets err_o. Fetch continues; no abort.
  - Burst ends on the first beat with rlast_i=1, or when beat_cnt reaches burst_words-1. A mismatch between the two (early or late rlast) sets err_o. After a late-rlast end, further beats until rlast are accepted but not pushed.
  - At burst end: cur_addr += burst_words*4, rem_words -= burst_words. Next state is DONE if rem_words is then 0, otherwise WAIT_SPACE.
- DONE: frame_done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 in WAIT_SPACE, ADDR and DATA.
- frame_start_i while busy: late_o pulses the same cycle.
  - In WAIT_SPACE: restart immediately from a fresh latch (back to WAIT_SPACE).
  - In ADDR/DATA: set restart_pending. At burst end, discard the remaining words and restart from a fresh latch; no frame_done_o pulse. restart_pending clears on restart.
- en_i deasserted:
  - In IDLE/WAIT_SPACE: go to IDLE next cycle, no frame_done_o.
  - In ADDR/DATA: the AXI transaction completes normally, then IDLE, no frame_done_o.
- frame_start_i with en_i=0 is ignored; late_o stays 0.
- err_o is cleared only by rst_i or by the next frame latch.
- rst_i mid-burst returns to IDLE with outputs 0. The external AXI interconnect is reset on the same rst_i.
- Arithmetic: cur_addr wraps modulo 2^ADDR_WIDTH. rem_words is 30 bits.

Test Plan:
- fbstart=0x1000, fbsize=64, brulen=3, fifo_free=16, arready/rvalid always 1 -> 4 bursts at 0x1000/0x1010/0x1020/0x1030, arlen=3 each, 16 pushes, frame_done_o pulse, busy_o low after.
- fbstart=0x0FF8, fbsize=32, brulen=7 -> bursts at 0x0FF8 arlen=1, then 0x1000 arlen=5; no 4 KB crossing.
- fbsize=20, brulen=3 -> arlen=3 then arlen=0 (1 beat); 5 pushes total.
- fifo_free=2, brulen=3 held 50 cycles -> arvalid_o stays 0; fifo_free set to 4 -> AR issued the next cycle.
- rresp=2'b10 on beat 2 of burst 1 -> err_o=1 sticky, all beats still pushed, frame_done_o pulses; next frame_start clears err_o.
- frame_start pulse mid-DATA with arready delayed 3 cycles -> late_o pulse; current burst completes, next AR at the new fbstart, no frame_done_o for the aborted frame.

Source files
------------

// File: rtl/vga_fb_fetch_ctrl.sv
// Framebuffer fetch scheduler: walks the framebuffer once per frame as single-outstanding
// AXI4 INCR read bursts, throttled on pixel-FIFO free space, and pushes beats into the FIFO.
module vga_fb_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_WIDTH  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  frame_start_i,
    input  logic [ADDR_WIDTH-1:0] fbstart_i,
    input  logic [31:0]           fbsize_i,
    input  logic [7:0]            brulen_i,
    input  logic [LVL_WIDTH-1:0]  fifo_free_i,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    output logic                  push_o,
    output logic [DATA_WIDTH-1:0] push_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_o,
    output logic                  late_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int CMP_WIDTH = (LVL_WIDTH > 9) ? LVL_WIDTH : 9;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [29:0]           rem_words;
    logic [8:0]            blen;
    logic [8:0]            burst_len;
    logic [7:0]            arlen_q;
    logic [7:0]            beat_cnt;
    logic                  err_q;
    logic                  drain;
    logic                  restart_pending;

    // Values taken on a frame latch (fresh start or restart).
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [29:0]           lat_rem;
    logic [8:0]            lat_blen;
    state_t                lat_state;

    assign lat_addr  = {fbstart_i[ADDR_WIDTH-1:2], 2'b00};
    assign lat_rem   = fbsize_i[31:2];
    assign lat_blen  = {1'b0, brulen_i} + 9'd1;
    assign lat_state = (lat_rem == '0) ? ST_DONE : ST_WAIT_SPACE;

    // Byte-offset bits are don't-care; the name keeps them out of unused-signal reports.
    logic unused_low_bits;
    assign unused_low_bits = ^{fbstart_i[1:0], fbsize_i[1:0]};

    // Burst size: the smallest of the programmed length, remaining words and words left in the 4 KB page.
    logic [10:0] page_words;
    logic [29:0] rem_or_blen;
    logic [8:0]  burst_calc;

    assign page_words  = 11'd1024 - {1'b0, cur_addr[11:2]};
    assign rem_or_blen = (rem_words < {21'd0, blen}) ? rem_words : {21'd0, blen};
    assign burst_calc  = (rem_or_blen < {19'd0, page_words}) ? rem_or_blen[8:0] : page_words[8:0];

    logic [CMP_WIDTH-1:0] free_ext;
    logic [CMP_WIDTH-1:0] need_ext;
    logic                 space_ok;

    assign free_ext = CMP_WIDTH'(fifo_free_i);
    assign need_ext = CMP_WIDTH'(burst_calc);
    assign space_ok = (free_ext >= need_ext);

    logic                  beat;
    logic                  last_beat;
    logic                  xfer_end;
    logic                  late;
    logic                  restart_now;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic [29:0]           rem_left;

    assign beat        = (state == ST_DATA) && rvalid_i;
    assign last_beat   = ({1'b0, beat_cnt} == (burst_len - 9'd1));
    // The AXI transaction itself only ends on rlast, even after a late-rlast drain.
    assign xfer_end    = beat && rlast_i;
    assign late        = frame_start_i && en_i && busy_o;
    assign restart_now = restart_pending || late;
    assign addr_step   = ADDR_WIDTH'({burst_len, 2'b00});
    assign rem_left    = drain ? rem_words : (rem_words - {21'd0, burst_len});

    assign busy_o       = (state == ST_WAIT_SPACE) || (state == ST_ADDR) || (state == ST_DATA);
    assign arvalid_o    = (state == ST_ADDR);
    assign araddr_o     = cur_addr;
    assign arlen_o      = arlen_q;
    assign rready_o     = (state == ST_DATA);
    assign push_o       = beat && !drain;
    assign push_data_o  = push_o ? rdata_i : '0;
    assign frame_done_o = (state == ST_DONE);
    assign err_o        = err_q;
    assign late_o       = late;

    // NOTE: reset is synchronous, so it lives inside the clocked block; later assignments
    // in the same branch win, which is how a restart latch overrides burst accounting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            cur_addr        <= '0;
            rem_words       <= '0;
            blen            <= '0;
            burst_len       <= '0;
            arlen_q         <= '0;
            beat_cnt        <= '0;
            err_q           <= 1'b0;
            drain           <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start_i && en_i) begin
                        cur_addr  <= lat_addr;
                        rem_words <= lat_rem;
                        blen      <= lat_blen;
                        err_q     <= 1'b0;
                        state     <= lat_state;
                    end
                end

                ST_WAIT_SPACE: begin
                    if (!en_i) begin
                        state <= ST_IDLE;
                    end else if (frame_start_i) begin
                        cur_addr  <= lat_addr;
                        rem_words <= lat_rem;
                        blen      <= lat_blen;
                        err_q     <= 1'b0;
                        state     <= lat_state;
                    end else if (space_ok) begin
                        burst_len <= burst_calc;
                        arlen_q   <= 8'(burst_calc - 9'd1);
                        state     <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (late) begin
                        restart_pending <= 1'b1;
                    end
                    if (arready_i) begin
                        beat_cnt <= '0;
                        drain    <= 1'b0;
                        state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (late) begin
                        restart_pending <= 1'b1;
                    end
                    if (beat) begin
                        if (rresp_i != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (!drain) begin
                            if (rlast_i || last_beat) begin
                                cur_addr  <= cur_addr + addr_step;
                                rem_words <= rem_words - {21'd0, burst_len};
                                if (rlast_i != last_beat) begin
                                    err_q <= 1'b1;
                                end
                                if (!rlast_i) begin
                                    drain <= 1'b1;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 8'd1;
                            end
                        end
                        if (xfer_end) begin
                            drain           <= 1'b0;
                            restart_pending <= 1'b0;
                            if (!en_i) begin
                                state <= ST_IDLE;
                            end else if (restart_now) begin
                                cur_addr  <= lat_addr;
                                rem_words <= lat_rem;
                                blen      <= lat_blen;
                                err_q     <= 1'b0;
                                state     <= lat_state;
                            end else begin
                                state <= (rem_left == '0) ? ST_DONE : ST_WAIT_SPACE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Self-checking bench for vga_fb_fetch_ctrl: acts as AXI read slave and pixel FIFO, and
// predicts the burst list of every frame from the address/size/length rules.
module tb_vga_fb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        frame_start;
    logic [31:0] fbstart;
    logic [31:0] fbsize;
    logic [7:0]  brulen;
    logic [9:0]  fifo_free;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        push;
    logic [31:0] push_data;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic        late;

    vga_fb_fetch_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LVL_WIDTH (10)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .frame_start_i(frame_start),
        .fbstart_i    (fbstart),
        .fbsize_i     (fbsize),
        .brulen_i     (brulen),
        .fifo_free_i  (fifo_free),
        .arvalid_o    (arvalid),
        .arready_i    (arready),
        .araddr_o     (araddr),
        .arlen_o      (arlen),
        .rvalid_i     (rvalid),
        .rready_o     (rready),
        .rdata_i      (rdata),
        .rresp_i      (rresp),
        .rlast_i      (rlast),
        .push_o       (push),
        .push_data_o  (push_data),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .err_o        (err),
        .late_o       (late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;

    logic [31:0] q_addr[$];
    int          q_len[$];

    logic [31:0] late_fs;
    logic [31:0] late_sz;
    logic [7:0]  late_bl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected burst list: greedy walk, each burst limited by length, remainder and 4 KB page.
    task automatic build_model(input logic [31:0] fs, input logic [31:0] sz, input logic [7:0] bl);
        logic [31:0] a;
        int rem;
        int max_len;
        int page;
        int n;
        a       = fs & 32'hFFFF_FFFC;
        rem     = int'(sz / 32'd4);
        max_len = int'(bl) + 1;
        q_addr.delete();
        q_len.delete();
        while (rem > 0) begin
            page = (4096 - int'(a % 32'd4096)) / 4;
            n    = max_len;
            if (rem < n) n = rem;
            if (page < n) n = page;
            q_addr.push_back(a);
            q_len.push_back(n);
            a   = a + 32'(4 * n);
            rem = rem - n;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        arready     = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rresp       = 2'b00;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] fs, input logic [31:0] sz, input logic [7:0] bl);
        tick();
        en          = 1'b1;
        fbstart     = fs;
        fbsize      = sz;
        brulen      = bl;
        frame_start = 1'b1;
        pushes      = 0;
        #1;
        check("late_idle_start", late, 0);
        build_model(fs, sz, bl);
    endtask

    // Serves one burst. ar_delay<0 randomises arready; rl_shift>0 sends extra beats
    // (late rlast), <0 fewer (early rlast); late_beat>=0 pulses frame_start before that beat.
    task automatic serve_burst(input logic [31:0] exp_addr, input int n, input int ar_delay,
                               input int rl_shift, input int resp_beat, input int late_beat,
                               input bit fast);
        int waited = 0;
        int cyc    = 0;
        int sent   = 0;
        int total;
        bit got    = 0;
        bit pulsed = 0;
        total = n + rl_shift;
        while (!got && waited < 300) begin
            tick();
            arready = (ar_delay < 0) ? ($urandom_range(0, 2) == 0) : (waited >= ar_delay);
            #1;
            if (arvalid) begin
                check("araddr", araddr, exp_addr);
                check("arlen", arlen, n - 1);
                check("busy_addr", busy, 1);
            end
            if (arvalid && arready) got = 1;
            else waited++;
        end
        check("ar_handshake_seen", got, 1);
        while (sent < total && cyc < 2000) begin
            tick();
            cyc++;
            if (late_beat == sent && !pulsed) begin
                pulsed      = 1;
                frame_start = 1'b1;
                fbstart     = late_fs;
                fbsize      = late_sz;
                brulen      = late_bl;
                #1;
                check("late_pulse", late, 1);
                check("push_idle", push, 0);
            end else begin
                rvalid = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (rvalid) begin
                    rdata = $urandom;
                    rlast = (sent == total - 1);
                    rresp = (sent == resp_beat) ? 2'b10 : 2'b00;
                    #1;
                    check("rready", rready, 1);
                    check("push", push, sent < n);
                    if (sent < n) begin
                        check("push_data", push_data, rdata);
                    end
                    if (push) pushes++;
                    sent++;
                end else begin
                    #1;
                    check("push_idle", push, 0);
                end
            end
        end
        check("beats_sent", sent, total);
    endtask

    task automatic run_bursts(input bit fast, input int resp_burst, input int resp_beat);
        for (int i = 0; i < q_addr.size(); i++) begin
            serve_burst(q_addr[i], q_len[i], fast ? 0 : -1, 0,
                        (i == resp_burst) ? resp_beat : -1, -1, fast);
        end
    endtask

    task automatic expect_done(input int want);
        int seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (frame_done) seen++;
        end
        check("frame_done_pulses", seen, want);
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
        logic [31:0] fs;
        logic [31:0] sz;
        logic [7:0]  bl;
        int          seen_ar;

        rst = 1'b1; en = 1'b0; frame_start = 1'b0;
        fbstart = '0; fbsize = '0; brulen = '0; fifo_free = 10'd1023;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        late_fs = '0; late_sz = '0; late_bl = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_rready", rready, 0);
        check("rst_push", push, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_late", late, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back 4-beat bursts with an always-ready slave.
        fifo_free = 10'd16;
        start_frame(32'h0000_1000, 32'd64, 8'd3);
        run_bursts(1, -1, -1);
        expect_done(1);
        check("t1_push_total", pushes, 16);
        check("t1_err", err, 0);
        fifo_free = 10'd1023;

        // 4 KB page split.
        start_frame(32'h0000_0FF8, 32'd32, 8'd7);
        run_bursts(0, -1, -1);
        expect_done(1);
        check("t2_push_total", pushes, 8);

        // Short tail burst.
        start_frame(32'h0000_2000, 32'd20, 8'd3);
        run_bursts(0, -1, -1);
        expect_done(1);
        check("t3_push_total", pushes, 5);

        // FIFO space throttle.
        fifo_free = 10'd2;
        start_frame(32'h0000_4000, 32'd16, 8'd3);
        seen_ar = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            #1;
            if (arvalid) seen_ar++;
        end
        check("throttle_no_ar", seen_ar, 0);
        check("throttle_busy", busy, 1);
        tick();
        fifo_free = 10'd4;
        tick();
        #1;
        check("throttle_release_ar", arvalid, 1);
        run_bursts(1, -1, -1);
        expect_done(1);
        fifo_free = 10'd1023;

        // Error response is sticky, fetch continues, next frame clears it.
        start_frame(32'h0000_2100, 32'd32, 8'd3);
        run_bursts(0, 0, 2);
        check("rresp_err_set", err, 1);
        expect_done(1);
        check("rresp_push_total", pushes, 8);
        check("rresp_err_sticky", err, 1);
        start_frame(32'h0000_2200, 32'd16, 8'd3);
        tick();
        #1;
        check("err_cleared_by_frame", err, 0);
        run_bursts(0, -1, -1);
        expect_done(1);

        // Late rlast (drained beats not pushed), then early rlast.
        start_frame(32'h0000_6000, 32'd48, 8'd3);
        serve_burst(32'h0000_6000, 4, -1, 2, -1, -1, 0);
        check("late_rlast_err", err, 1);
        serve_burst(32'h0000_6010, 4, -1, -1, -1, -1, 0);
        serve_burst(32'h0000_6020, 4, -1, 0, -1, -1, 0);
        expect_done(1);
        check("rlast_push_total", pushes, 11);
        check("rlast_err_sticky", err, 1);

        // Enable dropped while waiting for space, and frame_start ignored while disabled.
        fifo_free = 10'd0;
        start_frame(32'h0000_7000, 32'd16, 8'd3);
        tick();
        #1;
        check("en_drop_busy_before", busy, 1);
        en = 1'b0;
        tick();
        #1;
        check("en_drop_busy_after", busy, 0);
        check("en_drop_no_done", frame_done, 0);
        frame_start = 1'b1;
        #1;
        check("disabled_no_late", late, 0);
        tick();
        #1;
        check("disabled_stays_idle", busy, 0);
        fifo_free = 10'd1023;

        // frame_start mid-burst: current burst completes, restart at new base, no done.
        late_fs = 32'h0000_5000;
        late_sz = 32'd32;
        late_bl = 8'd7;
        start_frame(32'h0000_3000, 32'd64, 8'd3);
        serve_burst(32'h0000_3000, 4, 3, 0, -1, 2, 1);
        tick();
        #1;
        check("aborted_no_done", frame_done, 0);
        check("restart_busy", busy, 1);
        check("restart_err_clear", err, 0);
        build_model(late_fs, late_sz, late_bl);
        run_bursts(0, -1, -1);
        expect_done(1);

        // Address wrap at the top of the address space.
        start_frame(32'hFFFF_FFF0, 32'd32, 8'd7);
        run_bursts(0, -1, -1);
        expect_done(1);
        check("wrap_push_total", pushes, 8);

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            fs = $urandom;
            if ($urandom_range(0, 1) == 0) fs[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            sz = $urandom_range(0, 300);
            bl = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            fifo_free = 10'($urandom_range(256, 1023));
            start_frame(fs, sz, bl);
            run_bursts(0, -1, -1);
            expect_done(1);
            check("rand_push_total", pushes, int'(sz / 32'd4));
            check("rand_err", err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
